// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared constants and types for the AXI read/write arbiters.
//   arb_state_e  : arbitration FSM encoding (IDLE/ADDR/DATA/RESP)
//   NUM_MASTERS  : number of masters sharing the slave port
//   done_state() : where the FSM goes once the last W beat is accepted
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int IDX_W       = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  // With response tracking the owner keeps the port until B completes;
  // otherwise the port frees up as soon as the write data is done.
  function automatic arb_state_e done_state(input logic b_wait);
    return b_wait ? RESP : IDLE;
  endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_write_arbiter_if
// Request/handshake bundle between the interconnect write path and the arbiter.
//   m_awvalid      : per-master AWVALID requests
//   aw_hs/w_hs     : handshakes observed on the muxed slave AW / W ports
//   w_last         : WLAST on the muxed slave W port
//   b_hs           : handshake on the muxed B port
//   m_write_accept : one-hot grant steering the write-channel muxes
//   grant_idx      : encoded current / most recent grant
//   busy           : a grant is active
// Modports: master drives requests/handshakes, slave is the arbiter side.
// -----------------------------------------------------------------------------
interface axi_write_arbiter_if;
  import axi_arb_pkg::*;

  logic [NUM_MASTERS-1:0] m_awvalid;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   w_last;
  logic                   b_hs;
  logic [NUM_MASTERS-1:0] m_write_accept;
  logic [IDX_W-1:0]       grant_idx;
  logic                   busy;

  modport master (
    output m_awvalid, aw_hs, w_hs, w_last, b_hs,
    input  m_write_accept, grant_idx, busy
  );

  modport slave (
    input  m_awvalid, aw_hs, w_hs, w_last, b_hs,
    output m_write_accept, grant_idx, busy
  );

endinterface

// File: rtl/axi_write_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker for four requesters.
//   i_req [3:0] : request vector, bit i = requester i
//   i_ptr [1:0] : most recently granted index
//   o_idx [1:0] : winner, first set bit searching upward from i_ptr+1 (wrapping)
//   o_vld       : any request present
// -----------------------------------------------------------------------------
module rr_pick4
  import axi_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [IDX_W-1:0]       o_idx,
  output logic                   o_vld
);

  // Walk the search order backwards so the nearest requester after the
  // pointer is the last (and therefore winning) assignment.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    o_idx = '0;
    o_vld = |i_req;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = i_ptr + IDX_W'(k);
      if (i_req[cand]) o_idx = cand;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi_write_arbiter
// Round-robin owner arbitration for the shared AXI slave write port. One
// master holds AW, W and (optionally) B from address issue to completion.
//   B_WAIT  : 1 holds the grant until b_hs, 0 releases after the last W beat
//   aclk    : clock
//   aresetn : asynchronous active-low reset
//   bus     : request/handshake inputs and grant outputs (slave modport)
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter bit B_WAIT = 1'b1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_write_arbiter_if.slave   bus
);

  arb_state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0]       r_last_grant, w_last_grant_nxt;
  logic                   r_wdone, w_wdone_nxt;

  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_vld;
  logic                   w_wlast_hs;
  logic [NUM_MASTERS-1:0] w_accept;

  assign w_wlast_hs = bus.w_hs & bus.w_last;

  rr_pick4 u_pick (
    .i_req (bus.m_awvalid),
    .i_ptr (r_last_grant),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_MASTERS - 1);
      r_wdone      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_idx  <= w_grant_idx_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wdone      <= w_wdone_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_idx_nxt  = r_grant_idx;
    w_last_grant_nxt = r_last_grant;
    w_wdone_nxt      = r_wdone;

    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_grant_idx_nxt  = w_pick_idx;
          w_last_grant_nxt = w_pick_idx;
          w_state_nxt      = ADDR;
        end
      end
      ADDR: begin
        // Write data may complete before the address; remember it so the
        // address handshake can skip DATA. A same-cycle W-last counts too.
        if (w_wlast_hs) w_wdone_nxt = 1'b1;
        if (bus.aw_hs) begin
          if (r_wdone || w_wlast_hs) w_state_nxt = done_state(B_WAIT);
          else                       w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_wlast_hs) w_state_nxt = done_state(B_WAIT);
      end
      RESP: begin
        if (bus.b_hs) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_state_nxt == IDLE) w_wdone_nxt = 1'b0;
  end

  always_comb begin
    w_accept = '0;
    if (r_state != IDLE) w_accept[r_grant_idx] = 1'b1;
  end

  assign bus.m_write_accept = w_accept;
  assign bus.grant_idx      = r_grant_idx;
  assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_write_arbiter
// Directed bench: u_dut holds grants through B, u_dut0 releases after WLAST.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_axi_write_arbiter;

  logic aclk;
  logic aresetn;
  int   n_chk;
  int   n_err;

  axi_write_arbiter_if u_if ();
  axi_write_arbiter_if u_if0 ();

  axi_write_arbiter #(.B_WAIT(1'b1)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (u_if)
  );

  axi_write_arbiter #(.B_WAIT(1'b0)) u_dut0 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (u_if0)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr_in();
    u_if.m_awvalid  = '0; u_if.aw_hs  = 0; u_if.w_hs  = 0; u_if.w_last  = 0; u_if.b_hs  = 0;
    u_if0.m_awvalid = '0; u_if0.aw_hs = 0; u_if0.w_hs = 0; u_if0.w_last = 0; u_if0.b_hs = 0;
  endtask

  // One complete write on u_dut after the grant: AW, single W-last, B.
  task automatic finish_txn();
    u_if.aw_hs = 1; tick(); u_if.aw_hs = 0;
    u_if.w_hs = 1; u_if.w_last = 1; tick(); u_if.w_hs = 0; u_if.w_last = 0;
    u_if.b_hs = 1; tick(); u_if.b_hs = 0;
  endtask

  task automatic do_reset();
    aresetn = 0;
    tick();
    tick();
    aresetn = 1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clr_in();
    aresetn = 0;
    #2;
    chk("rst_accept", 32'(u_if.m_write_accept), 32'h0);
    chk("rst_grant",  32'(u_if.grant_idx),      32'h0);
    chk("rst_busy",   32'(u_if.busy),           32'h0);
    tick();
    aresetn = 1;

    // Single request from master 2, four-beat burst.
    u_if.m_awvalid = 4'b0100;
    tick();
    u_if.m_awvalid = 4'b0000;
    chk("single_accept", 32'(u_if.m_write_accept), 32'h4);
    chk("single_grant",  32'(u_if.grant_idx),      32'h2);
    chk("single_busy",   32'(u_if.busy),           32'h1);
    u_if.aw_hs = 1; tick(); u_if.aw_hs = 0;
    u_if.w_hs = 1;
    tick(); tick(); tick();
    chk("single_mid_burst", 32'(u_if.m_write_accept), 32'h4);
    u_if.w_last = 1; tick(); u_if.w_hs = 0; u_if.w_last = 0;
    chk("single_resp", 32'(u_if.m_write_accept), 32'h4);
    u_if.b_hs = 1; tick(); u_if.b_hs = 0;
    chk("single_rel_accept", 32'(u_if.m_write_accept), 32'h0);
    chk("single_rel_busy",   32'(u_if.busy),           32'h0);
    chk("single_rel_grant",  32'(u_if.grant_idx),      32'h2);

    // Rotation from reset with all masters requesting continuously.
    do_reset();
    u_if.m_awvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rot_grant",  32'(u_if.grant_idx),      32'(k % 4));
      chk("rot_accept", 32'(u_if.m_write_accept), 32'(1 << (k % 4)));
      finish_txn();
      chk("rot_gap_busy", 32'(u_if.busy), 32'h0);
    end
    u_if.m_awvalid = 4'b0000;
    tick();

    // Pointer wrap: after master 2, masters 0 and 1 request; 0 comes first.
    u_if.m_awvalid = 4'b0100; tick(); u_if.m_awvalid = 4'b0000;
    chk("wrap_pre_grant", 32'(u_if.grant_idx), 32'h2);
    finish_txn();
    u_if.m_awvalid = 4'b0011; tick(); u_if.m_awvalid = 4'b0000;
    chk("wrap_grant",  32'(u_if.grant_idx),      32'h0);
    chk("wrap_accept", 32'(u_if.m_write_accept), 32'h1);
    finish_txn();

    // W before AW: the FSM must land in RESP, so b_hs ends the grant.
    u_if.m_awvalid = 4'b0010; tick(); u_if.m_awvalid = 4'b0000;
    chk("wfirst_accept", 32'(u_if.m_write_accept), 32'h2);
    u_if.w_hs = 1; u_if.w_last = 1; tick(); u_if.w_hs = 0; u_if.w_last = 0;
    tick();
    u_if.aw_hs = 1; tick(); u_if.aw_hs = 0;
    chk("wfirst_resp_busy", 32'(u_if.busy), 32'h1);
    u_if.b_hs = 1; tick(); u_if.b_hs = 0;
    chk("wfirst_done_busy", 32'(u_if.busy), 32'h0);

    // wdone must be clear again, and W-last seen in IDLE must not set it:
    // after AW the FSM is in DATA, where b_hs is ignored.
    u_if.m_awvalid = 4'b0001; u_if.w_hs = 1; u_if.w_last = 1; tick();
    u_if.m_awvalid = 4'b0000; u_if.w_hs = 0; u_if.w_last = 0;
    chk("wclr_grant", 32'(u_if.grant_idx), 32'h0);
    u_if.aw_hs = 1; tick(); u_if.aw_hs = 0;
    u_if.b_hs = 1; tick(); u_if.b_hs = 0;
    chk("wclr_b_ignored", 32'(u_if.busy), 32'h1);
    u_if.w_hs = 1; u_if.w_last = 1; tick(); u_if.w_hs = 0; u_if.w_last = 0;
    chk("wclr_resp_busy", 32'(u_if.busy), 32'h1);
    u_if.b_hs = 1; tick(); u_if.b_hs = 0;
    chk("wclr_done_busy", 32'(u_if.busy), 32'h0);

    // B_WAIT=0: release right after the W-last handshake.
    u_if0.m_awvalid = 4'b0001; tick(); u_if0.m_awvalid = 4'b0000;
    chk("nb_accept", 32'(u_if0.m_write_accept), 32'h1);
    u_if0.aw_hs = 1; tick(); u_if0.aw_hs = 0;
    u_if0.w_hs = 1; tick();
    chk("nb_data_accept", 32'(u_if0.m_write_accept), 32'h1);
    u_if0.w_last = 1; tick(); u_if0.w_hs = 0; u_if0.w_last = 0;
    chk("nb_rel_accept", 32'(u_if0.m_write_accept), 32'h0);
    chk("nb_rel_busy",   32'(u_if0.busy),           32'h0);
    u_if0.b_hs = 1; tick(); u_if0.b_hs = 0;
    chk("nb_b_ignored", 32'(u_if0.busy), 32'h0);
    // Simultaneous AW and W-last in ADDR goes straight back to IDLE.
    u_if0.m_awvalid = 4'b1000; tick(); u_if0.m_awvalid = 4'b0000;
    chk("nb_sim_grant", 32'(u_if0.grant_idx), 32'h3);
    u_if0.aw_hs = 1; u_if0.w_hs = 1; u_if0.w_last = 1; tick();
    u_if0.aw_hs = 0; u_if0.w_hs = 0; u_if0.w_last = 0;
    chk("nb_sim_busy", 32'(u_if0.busy), 32'h0);

    // Async reset in DATA while master 1 owns the port.
    u_if.m_awvalid = 4'b0010; tick(); u_if.m_awvalid = 4'b0000;
    u_if.aw_hs = 1; tick(); u_if.aw_hs = 0;
    u_if.w_hs = 1; tick(); u_if.w_hs = 0;
    chk("ar_pre_accept", 32'(u_if.m_write_accept), 32'h2);
    #2;
    aresetn = 0;
    #1;
    chk("ar_accept", 32'(u_if.m_write_accept), 32'h0);
    chk("ar_busy",   32'(u_if.busy),           32'h0);
    chk("ar_grant",  32'(u_if.grant_idx),      32'h0);
    tick();
    aresetn = 1;
    u_if.m_awvalid = 4'b1111; tick(); u_if.m_awvalid = 4'b0000;
    chk("ar_prio_grant",  32'(u_if.grant_idx),      32'h0);
    chk("ar_prio_accept", 32'(u_if.m_write_accept), 32'h1);
    finish_txn();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Round-robin arbiter for the AXI write path. It shares one slave write port among four masters. One master owns the AW, W and B channels from address issue to write-response completion. It sits beside the read-side arbiter in the interconnect and drives one-hot accept signals that steer the write-channel muxes.

## Interface
- B_WAIT, default 1: 1 holds the grant until the B handshake; 0 releases the grant after the last W beat.
- aclk  input  1  clock.
- aresetn  input  1  reset; asynchronous, active-low.
- m_awvalid  input  4  per-master AWVALID; bit i is master i.
- aw_hs  input  1  AWVALID&&AWREADY observed on the muxed slave AW port.
- w_hs  input  1  WVALID&&WREADY on the muxed slave W port.
- w_last  input  1  WLAST on the muxed slave W port.
- b_hs  input  1  BVALID&&BREADY on the muxed B port.
- m_write_accept  output  4  one-hot grant; all zero when idle.
- grant_idx  output  2  encoded index of the current or most recent grant.
- busy  output  1  high while any grant is active.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Nothing is granted.
  - If any m_awvalid bit is set, pick the first requester searching upward from last_grant+1, wrapping modulo 4.
  - Register the winner in grant_idx and last_grant, then go to ADDR.
- ADDR: wait for aw_hs.
  - If aw_hs arrives and wdone is set, go to RESP when B_WAIT=1, or IDLE when B_WAIT=0.
  - If aw_hs arrives and wdone is clear, go to DATA.
- DATA: on w_hs&&w_last, go to RESP when B_WAIT=1, or IDLE when B_WAIT=0. Non-last beats do not change state.
- RESP: on b_hs, go to IDLE.
- wdone flag covers W data that arrives before AW:
  - It is set by w_hs&&w_last while in ADDR.
  - It is cleared on every entry to IDLE.
- Requests are neither queued nor sampled outside IDLE. A master that drops awvalid while ungranted loses its turn silently.
- Priority pointer: last_grant resets to 3, so master 0 has top priority after reset.
- Events in an illegal state are ignored, and the default branch forces the FSM to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - m_write_accept 4'b0000.
  - grant_idx 2'd0.
  - busy 0.
  - last_grant 2'd3.
  - wdone 0.
- All outputs are decoded from registers, with no combinational path from inputs to outputs.
  - m_write_accept = (state!=IDLE) ? 1<<grant_idx : 0.
  - busy = (state!=IDLE).
- Grant latency: m_awvalid seen in IDLE at edge N produces accept high after edge N, i.e. visible in cycle N+1.
- Release: the completing handshake (b_hs, or w_last when B_WAIT=0) is sampled at edge N. Accept drops after edge N and the FSM is in IDLE in cycle N+1.
- Back-to-back grants: the earliest next grant is in cycle N+2, giving one idle cycle between owners.
- Simultaneous aw_hs and w_hs&&w_last in ADDR counts as both. The FSM skips DATA and goes to RESP, or to IDLE when B_WAIT=0.
- b_hs outside RESP is ignored, and w_hs in IDLE is ignored.
- When aresetn is asserted mid-burst, all registers return to their reset values immediately. Outputs go to zero asynchronously.

## Structure
- Shared package axi_arb_pkg holds:
  - state encoding constants IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3;
  - NUM_MASTERS=4.
- The read arbiter uses the same package constants.
- Natural sub-module: rr_pick4. It is combinational and maps the 4-bit request and 2-bit pointer to a 2-bit winner plus a valid flag. It is shared with any future round-robin refit of the read arbiter.

## Test plan
- Reset then single request: m_awvalid=4'b0100, then aw_hs, then 4 w_hs with w_last on the 4th, then b_hs.
  - Accept 4'b0100 from cycle 1 through the b_hs cycle.
  - Accept 0 and busy 0 one cycle later.
- Rotation: m_awvalid=4'b1111 held for four full transactions. Grant order is 0,1,2,3, then 0 again.
- Pointer wrap: last_grant=2 and m_awvalid=4'b0011. Master 0 wins, skipping the lower-priority master 1.
- W before AW: a single-beat w_hs&&w_last in ADDR, with aw_hs two cycles later. The FSM goes ADDR→RESP without entering DATA, and wdone clears on return to IDLE.
- B_WAIT=0: w_last handshake at cycle N. Accept drops in cycle N+1, and a subsequent b_hs has no effect.
- Async reset during DATA, with accept 4'b0010 active: outputs go to zero without a clock edge. After release, master 0 has top priority.
